// File: rtl/sc_scbc_irq_ctrl.sv
// sc_scbc_irq_ctrl: interrupt status/enable block behind the SCBC register decoder.
// Sticky W1C status per source, enable mask, edge/level mode, W1S test register,
// lowest-index pending vector and one registered IRQ line.
module sc_scbc_irq_ctrl #(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0010,
    parameter logic [31:0] MODE_INIT = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               reg_we,
    input  logic               reg_re,
    input  logic [15:0]        reg_addr,
    input  logic [3:0]         reg_be,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_ack,
    output logic               irq
);

    localparam logic [13:0] BASE_WORD = BASE_ADDR[15:2];

    localparam logic [2:0] OFF_ISR  = 3'd0;
    localparam logic [2:0] OFF_IER  = 3'd1;
    localparam logic [2:0] OFF_MSR  = 3'd2;
    localparam logic [2:0] OFF_MODE = 3'd3;
    localparam logic [2:0] OFF_SET  = 3'd4;
    localparam logic [2:0] OFF_VEC  = 3'd5;

    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [NUM_SRC-1:0] ier_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] src_d_q;
    logic [NUM_SRC-1:0] msr;
    logic [NUM_SRC-1:0] ev;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] wval;

    logic [31:0] byte_mask;
    logic [31:0] wdata_m;
    logic [13:0] word_off;
    logic        hit;
    logic        wr_isr, wr_ier, wr_mode, wr_set;
    logic        rd_en;
    logic [31:0] rd_val;
    logic [4:0]  vec_idx;
    logic [31:0] vec_val;
    logic        unused_bits;

    // Address decode and byte-masked write data
    always_comb begin
        byte_mask = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
        wdata_m   = reg_wdata & byte_mask;
        wval      = wdata_m[NUM_SRC-1:0];
        // Addresses below the base wrap to a large offset and miss
        word_off  = reg_addr[15:2] - BASE_WORD;
        hit       = (word_off < 14'd6);
        wr_isr    = reg_we && hit && (word_off[2:0] == OFF_ISR);
        wr_ier    = reg_we && hit && (word_off[2:0] == OFF_IER);
        wr_mode   = reg_we && hit && (word_off[2:0] == OFF_MODE);
        wr_set    = reg_we && hit && (word_off[2:0] == OFF_SET);
        // A simultaneous write and read is treated as a write only
        rd_en     = reg_re && !reg_we;
    end

    assign unused_bits = ^{reg_addr[1:0], wdata_m};

    // Event detection, masked status and next status
    always_comb begin
        msr   = isr_q & ier_q;
        ev    = (mode_q & src & ~src_d_q) | (~mode_q & src);
        clr   = wr_isr ? wval : '0;
        set   = wr_set ? wval : '0;
        // Events and SET are ORed after the clear so nothing is lost in a collision
        isr_d = (isr_q & ~clr) | ev | set;
    end

    // Lowest pending index among enabled status bits
    always_comb begin
        vec_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (msr[i]) begin
                vec_idx = 5'(i);
            end
        end
        vec_val = {|msr, 26'b0, vec_idx};
    end

    // Read data mux; unmapped offsets and SET read as zero
    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (word_off[2:0])
                OFF_ISR:  rd_val = 32'(isr_q);
                OFF_IER:  rd_val = 32'(ier_q);
                OFF_MSR:  rd_val = 32'(msr);
                OFF_MODE: rd_val = 32'(mode_q);
                OFF_VEC:  rd_val = vec_val;
                default:  rd_val = '0;
            endcase
        end
    end

    // Interrupt state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            isr_q   <= '0;
            ier_q   <= '0;
            mode_q  <= MODE_INIT[NUM_SRC-1:0];
            src_d_q <= '0;
            irq     <= 1'b0;
        end else begin
            isr_q   <= isr_d;
            src_d_q <= src;
            irq     <= |msr;
            if (wr_ier) begin
                ier_q <= wval;
            end
            if (wr_mode) begin
                mode_q <= wval;
            end
        end
    end

    // Bus acknowledge and held read data
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ack <= reg_we | reg_re;
            if (rd_en) begin
                reg_rdata <= rd_val;
            end
        end
    end

endmodule
